// File: rtl/dffe_ctrl_pkg.sv
// Shared types and constants for the downstream enabled-flip-flop load controller.
// Holds the FSM state encoding, FIFO depth, counter widths and a pointer-wrap helper.
package dffe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int LOAD_CNT_W = 8;
    localparam int GAP_W      = 4;

    // Advance a FIFO pointer, wrapping at the last slot.
    function automatic logic [FIFO_PTR_W-1:0] next_ptr(input logic [FIFO_PTR_W-1:0] ptr);
        if (ptr == FIFO_PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return ptr + FIFO_PTR_W'(1);
    endfunction

endpackage

// File: rtl/dffe_ctrl_fifo.sv
// Small synchronous FIFO buffering producer words ahead of the load FSM.
// Push and pop in the same cycle keep the occupancy unchanged and preserve order.
module dffe_ctrl_fifo
    import dffe_ctrl_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic [FIFO_CNT_W-1:0] count,
    output logic                  full,
    output logic                  empty
);

    logic [WIDTH-1:0]      mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] rd_ptr;
    logic [FIFO_PTR_W-1:0] wr_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!srst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + FIFO_CNT_W'(1);
                2'b01:   count <= count - FIFO_CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/dffe_load_ctrl.sv
// Paces buffered words into a downstream enabled flip-flop: one registered EN pulse
// per word, followed by GAP enforced idle cycles, with a wrapping pulse counter.
module dffe_load_ctrl
    import dffe_ctrl_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int GAP   = 3
) (
    input  logic                  CLK,
    input  logic                  SRST,
    input  logic [WIDTH-1:0]      IN_DATA,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic [WIDTH-1:0]      D,
    output logic                  EN,
    output logic [LOAD_CNT_W-1:0] LOAD_CNT,
    output logic [1:0]            FSM_STATE
);

    // Handshake: a word transfers on a rising edge where IN_VALID and IN_READY are
    // both 1; IN_READY never depends on IN_VALID, only on occupancy and reset.

    localparam logic [GAP_W-1:0] GAP_M1 = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    state_t                  state;
    state_t                  next_state;
    logic [GAP_W-1:0]        wait_cnt;
    logic [GAP_W-1:0]        next_wait;
    logic                    load_go;
    logic                    push;
    logic [WIDTH-1:0]        head;
    logic [FIFO_CNT_W-1:0]   count;
    logic                    full;
    logic                    empty;
    logic [WIDTH-1:0]        d_q;
    logic                    en_q;
    logic [LOAD_CNT_W-1:0]   load_cnt_q;

    assign IN_READY  = SRST && !full;
    assign push      = IN_VALID && IN_READY;
    assign D         = d_q;
    assign EN        = en_q;
    assign LOAD_CNT  = load_cnt_q;
    assign FSM_STATE = state;

    dffe_ctrl_fifo #(
        .WIDTH(WIDTH)
    ) u_fifo (
        .clk       (CLK),
        .srst      (SRST),
        .push      (push),
        .push_data (IN_DATA),
        .pop       (load_go),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge CLK) begin
        if (!SRST) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            en_q       <= 1'b0;
            d_q        <= '0;
            load_cnt_q <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait;
            en_q     <= load_go;
            if (load_go) begin
                d_q        <= head;
                load_cnt_q <= load_cnt_q + LOAD_CNT_W'(1);
            end
        end
    end

    // The decision to load looks at occupancy before this edge's push, so a word
    // accepted at edge k is loaded at edge k+1 at the earliest.
    always_comb begin
        next_state = state;
        next_wait  = wait_cnt;
        load_go    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    next_state = ST_LOAD;
                    load_go    = 1'b1;
                end
            end
            ST_LOAD: begin
                if (GAP == 0) begin
                    if (!empty) begin
                        next_state = ST_LOAD;
                        load_go    = 1'b1;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end else begin
                    next_state = ST_WAIT;
                    next_wait  = GAP_M1;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    if (!empty) begin
                        next_state = ST_LOAD;
                        load_go    = 1'b1;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end else begin
                    next_wait = wait_cnt - GAP_W'(1);
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // unused in the datapath; occupancy is consumed through full/empty
    logic unused_count;
    assign unused_count = ^count;

endmodule

// File: tb/tb_dffe_load_ctrl.sv
// Directed bench for dffe_load_ctrl: one GAP=3 instance (index 0) and one GAP=0
// instance (index 1) sharing clock and reset, each with its own producer inputs.
module tb_dffe_load_ctrl;

    logic       clk = 1'b0;
    logic       srst;
    logic [1:0] in_valid;
    logic [1:0] in_data [2];
    logic [1:0] in_ready;
    logic [1:0] d [2];
    logic [1:0] en;
    logic [7:0] lc [2];
    logic [1:0] st [2];

    int passed = 0;
    int total  = 0;
    int lc_exp [2];

    always #5 clk = ~clk;

    dffe_load_ctrl #(.WIDTH(2), .GAP(3)) u_gap3 (
        .CLK(clk), .SRST(srst), .IN_DATA(in_data[0]), .IN_VALID(in_valid[0]),
        .IN_READY(in_ready[0]), .D(d[0]), .EN(en[0]), .LOAD_CNT(lc[0]), .FSM_STATE(st[0])
    );

    dffe_load_ctrl #(.WIDTH(2), .GAP(0)) u_gap0 (
        .CLK(clk), .SRST(srst), .IN_DATA(in_data[1]), .IN_VALID(in_valid[1]),
        .IN_READY(in_ready[1]), .D(d[1]), .EN(en[1]), .LOAD_CNT(lc[1]), .FSM_STATE(st[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        srst       = 1'b0;
        in_valid   = 2'b11;
        in_data[0] = 2'b11;
        in_data[1] = 2'b11;
        for (int c = 0; c < 2; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                total++;
                if (in_ready[i] !== 1'b0 || en[i] !== 1'b0 || d[i] !== 2'b00 || lc[i] !== 8'd0) begin
                    $display("FAIL reset_hold inst%0d cyc%0d: ready=%b en=%b d=%b cnt=%0d, required 0/0/00/0",
                             i, c, in_ready[i], en[i], d[i], lc[i]);
                end else passed++;
            end
        end
        srst     = 1'b1;
        in_valid = 2'b00;
        for (int c = 0; c < 6; c++) begin
            tick();
            total++;
            if (en !== 2'b00 || lc[0] !== 8'd0 || lc[1] !== 8'd0) begin
                $display("FAIL reset_release cyc%0d: en=%b cnt0=%0d cnt1=%0d, required en=00 cnt=0",
                         c, en, lc[0], lc[1]);
            end else passed++;
        end
        lc_exp[0] = 0;
        lc_exp[1] = 0;
    endtask

    task automatic test_single();
        in_data[0]  = 2'b01;
        in_valid[0] = 1'b1;
        total++;
        if (in_ready[0] !== 1'b1) $display("FAIL single_ready: got %b required 1", in_ready[0]);
        else passed++;
        tick();
        in_valid[0] = 1'b0;
        total++;
        if (en[0] !== 1'b0) $display("FAIL single_pre_en: got %b required 0", en[0]);
        else passed++;
        tick();
        lc_exp[0]++;
        total++;
        if (en[0] !== 1'b1 || d[0] !== 2'b01 || lc[0] !== 8'(lc_exp[0])) begin
            $display("FAIL single_pulse: en=%b d=%b cnt=%0d, required en=1 d=01 cnt=%0d",
                     en[0], d[0], lc[0], lc_exp[0]);
        end else passed++;
        for (int c = 0; c < 6; c++) begin
            tick();
            total++;
            if (en[0] !== 1'b0 || d[0] !== 2'b01 || lc[0] !== 8'(lc_exp[0])) begin
                $display("FAIL single_hold cyc%0d: en=%b d=%b cnt=%0d, required en=0 d=01 cnt=%0d",
                         c, en[0], d[0], lc[0], lc_exp[0]);
            end else passed++;
        end
    endtask

    task automatic test_burst(input int sel, input int spacing, input bit expect_stall);
        logic [1:0] got_d [$];
        int         got_t [$];
        bit         stalled = 1'b0;
        bit         timeout = 1'b0;
        fork
            begin
                for (int w = 0; w < 4; w++) begin
                    bit accepted = 1'b0;
                    int guard    = 0;
                    in_data[sel]  = 2'(w);
                    in_valid[sel] = 1'b1;
                    while (!accepted && guard < 30) begin
                        bit rdy;
                        @(negedge clk);
                        rdy = in_ready[sel];
                        if (!rdy) stalled = 1'b1;
                        tick();
                        accepted = rdy;
                        guard++;
                    end
                    if (!accepted) timeout = 1'b1;
                end
                in_valid[sel] = 1'b0;
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    tick();
                    if (en[sel] === 1'b1) begin
                        got_d.push_back(d[sel]);
                        got_t.push_back(c);
                    end
                end
            end
        join
        total++;
        if (timeout || got_d.size() != 4) begin
            $display("FAIL burst%0d_pulses: got %0d pulses (timeout=%b), required 4", sel, got_d.size(), timeout);
        end else begin
            passed++;
            for (int i = 0; i < 4; i++) begin
                total++;
                if (got_d[i] !== 2'(i)) $display("FAIL burst%0d_data%0d: got %b required %b", sel, i, got_d[i], 2'(i));
                else passed++;
            end
            for (int i = 1; i < 4; i++) begin
                total++;
                if (got_t[i] - got_t[i-1] != spacing) begin
                    $display("FAIL burst%0d_spacing%0d: got %0d required %0d", sel, i, got_t[i] - got_t[i-1], spacing);
                end else passed++;
            end
        end
        lc_exp[sel] += 4;
        total++;
        if (lc[sel] !== 8'(lc_exp[sel])) $display("FAIL burst%0d_count: got %0d required %0d", sel, lc[sel], lc_exp[sel]);
        else passed++;
        if (expect_stall) begin
            total++;
            if (!stalled) $display("FAIL burst%0d_ready_drop: got no stall required a stall", sel);
            else passed++;
        end
    endtask

    task automatic test_reset_in_wait();
        in_valid[0] = 1'b1;
        in_data[0]  = 2'b01;
        tick();
        in_data[0]  = 2'b10;
        tick();
        in_data[0]  = 2'b11;
        tick();
        in_valid[0] = 1'b0;
        total++;
        if (in_ready[0] !== 1'b0 || en[0] !== 1'b0) begin
            $display("FAIL rwait_pre: ready=%b en=%b, required 0/0", in_ready[0], en[0]);
        end else passed++;
        srst = 1'b0;
        tick();
        total++;
        if (in_ready[0] !== 1'b0) $display("FAIL rwait_ready_in_reset: got %b required 0", in_ready[0]);
        else passed++;
        srst = 1'b1;
        lc_exp[0] = 0;
        lc_exp[1] = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            total++;
            if (en[0] !== 1'b0 || in_ready[0] !== 1'b1 || lc[0] !== 8'd0) begin
                $display("FAIL rwait_post cyc%0d: en=%b ready=%b cnt=%0d, required 0/1/0",
                         c, en[0], in_ready[0], lc[0]);
            end else passed++;
        end
    endtask

    task automatic test_wrap();
        int  pulses  = 0;
        bit  timeout = 1'b0;
        fork
            begin
                for (int w = 0; w < 256; w++) begin
                    bit accepted = 1'b0;
                    int guard    = 0;
                    in_data[1]  = 2'(w);
                    in_valid[1] = 1'b1;
                    while (!accepted && guard < 10) begin
                        bit rdy;
                        @(negedge clk);
                        rdy = in_ready[1];
                        tick();
                        accepted = rdy;
                        guard++;
                    end
                    if (!accepted) timeout = 1'b1;
                end
                in_valid[1] = 1'b0;
            end
            begin
                for (int c = 0; c < 320; c++) begin
                    tick();
                    if (en[1] === 1'b1) begin
                        pulses++;
                        if (pulses == 255) begin
                            total++;
                            if (lc[1] !== 8'd255) $display("FAIL wrap_255: got %0d required 255", lc[1]);
                            else passed++;
                        end
                        if (pulses == 256) begin
                            total++;
                            if (lc[1] !== 8'd0) $display("FAIL wrap_256: got %0d required 0", lc[1]);
                            else passed++;
                            total++;
                            if (d[1] !== 2'b11) $display("FAIL wrap_last_data: got %b required 11", d[1]);
                            else passed++;
                        end
                    end
                end
            end
        join
        total++;
        if (timeout || pulses != 256) $display("FAIL wrap_pulses: got %0d (timeout=%b) required 256", pulses, timeout);
        else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_burst(0, 4, 1'b1);
        test_burst(1, 1, 1'b0);
        test_reset_in_wait();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dffe_load_ctrl.md
DFFE_LOAD_CTRL -- requirements
Module: dffe_load_ctrl

Interface
REQ-001 Parameter WIDTH, default 2, SHALL set the data width of IN_DATA and D.
REQ-002 Parameter GAP, default 3, range 0..15, SHALL set the number of idle cycles enforced after each EN pulse.
REQ-003 CLK  input  1  SHALL be the single clock; all state SHALL change on its rising edge only.
REQ-004 SRST  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 IN_DATA  input  WIDTH  SHALL carry the data word offered by the producer.
REQ-006 IN_VALID  input  1  SHALL indicate that IN_DATA is valid.
REQ-007 IN_READY  output  1  SHALL indicate that the block can accept a word this cycle.
REQ-008 D  output  WIDTH  SHALL carry the data presented to the downstream enabled flip-flop.
REQ-009 EN  output  1  SHALL be the load-enable for the downstream enabled flip-flop.
REQ-010 LOAD_CNT  output  8  SHALL count issued EN pulses.

Function
REQ-011 The block SHALL buffer up to 2 words in a FIFO; IN_READY SHALL be 1 exactly when fewer than 2 words are held and SRST is 1.
REQ-012 A word SHALL be accepted at a rising edge where IN_VALID=1 and IN_READY=1; otherwise IN_DATA SHALL be ignored.
REQ-013 The FSM SHALL have exactly three states: IDLE, LOAD and WAIT.
REQ-014 IDLE: if the FIFO holds at least 1 word at the edge, the next state SHALL be LOAD, D SHALL take the head word and the head SHALL be popped; otherwise the FSM SHALL stay in IDLE.
REQ-015 EN SHALL be 1 exactly while the FSM is in LOAD and SHALL be registered with no combinational path from the inputs.
REQ-016 LOAD lasts 1 cycle, then WAIT for GAP cycles; with GAP=0, LOAD SHALL be followed by the IDLE decision directly in the same edge.
REQ-017 On the final WAIT edge (or the LOAD edge when GAP=0), the FSM SHALL go to LOAD with pop if the FIFO is non-empty, else to IDLE.
REQ-018 Consecutive EN pulses SHALL therefore be spaced exactly GAP+1 cycles apart while data is available.
REQ-019 Latency: a word accepted at edge k into an empty FIFO with the FSM in IDLE SHALL produce EN=1 and D=word between edges k+1 and k+2.
REQ-020 D SHALL hold its last loaded value outside LOAD.
REQ-021 A simultaneous push and pop SHALL leave the count unchanged and preserve FIFO order.
REQ-022 LOAD_CNT SHALL increment by 1 on every entry to LOAD and SHALL wrap from 255 to 0.

Reset
REQ-023 SRST=0 at a rising edge SHALL set: FIFO empty, FSM state IDLE, D=0, EN=0, LOAD_CNT=0.
REQ-024 While SRST=0, IN_READY SHALL be 0 and no word SHALL be accepted.
REQ-025 Reset during LOAD or WAIT SHALL discard buffered words; no EN pulse SHALL follow for pre-reset data.

Structure
REQ-026 Package dffe_ctrl_pkg SHALL hold the FSM state enum, the FIFO depth constant (2) and the LOAD_CNT width constant (8).
REQ-027 The 2-entry FIFO SHALL be the sub-module dffe_ctrl_fifo (push/pop, count, head output); the FSM, D/EN registers and counter SHALL live in the top level.

Verification (WIDTH=2, GAP=3 unless stated)
REQ-028 Hold SRST=0 for 2 cycles with IN_VALID=1 and IN_DATA=11 -> IN_READY=0, EN=0, D=00, LOAD_CNT=0 throughout; no pulse after release.
REQ-029 Single word 01 accepted at edge k -> EN=1 and D=01 for exactly cycle k+1..k+2; then EN=0 and D=01 held; LOAD_CNT=1.
REQ-030 Offer 00, 01, 10, 11 with IN_VALID held at 1 -> IN_READY drops while 2 words are held; EN pulses exactly 4 cycles apart with D=00, 01, 10, 11 in order; LOAD_CNT=4.
REQ-031 GAP=0, same burst -> EN=1 on 4 consecutive cycles, D stepping 00, 01, 10, 11.
REQ-032 Assert SRST=0 in WAIT with 2 words buffered -> after release EN stays 0, IN_READY=1, LOAD_CNT=0.
REQ-033 Issue 256 loads -> LOAD_CNT reads 255 after the 255th and 0 after the 256th.
